// File: rtl/vending_machine_pkg.sv
// Shared constants and state type for the single-product vending controller.
// Price 15, coins 5 and 10, and the 2-bit coin/change encodings live here.
package vending_machine_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CR5  = 2'd1,
    CR10 = 2'd2
  } state_t;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;
  localparam logic [1:0] COIN_BAD  = 2'b11;

  localparam logic [1:0] CHG_NONE = 2'b00;
  localparam logic [1:0] CHG_5    = 2'b01;
  localparam logic [1:0] CHG_10   = 2'b10;

  localparam int PRICE = 15;

endpackage

// File: rtl/vending_machine_if.sv
// Coin-in / dispense / change bundle between the coin decoder and the actuators.
// master drives the coin code; slave (the controller) drives dispense and change.
interface vending_machine_if;

  logic [1:0] in;
  logic       out;
  logic [1:0] change;

  modport master (output in, input out, input change);
  modport slave  (input in, output out, output change);

endinterface

// File: rtl/vending_machine.sv
// Vending FSM: credits 5/10 coins, dispenses at 15, refunds on an idle cycle.
// Optional sale counter enabled by defining VM_SALE_CNT_EN.
module vending_machine
  import vending_machine_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  vending_machine_if.slave  bus
`ifdef VM_SALE_CNT_EN
  ,
  output logic [7:0]        sale_count
`endif
);

  state_t state;

  // Single registered FSM: outputs are pulses set on the transition edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      bus.out    <= 1'b0;
      bus.change <= CHG_NONE;
    end else begin
      bus.out    <= 1'b0;
      bus.change <= CHG_NONE;
      case (state)
        IDLE: begin
          case (bus.in)
            COIN_5:  state <= CR5;
            COIN_10: state <= CR10;
            default: state <= IDLE;
          endcase
        end
        CR5: begin
          case (bus.in)
            COIN_NONE: begin
              state      <= IDLE;
              bus.change <= CHG_5;
            end
            COIN_5:  state <= CR10;
            COIN_10: begin
              state   <= IDLE;
              bus.out <= 1'b1;
            end
            default: state <= CR5;
          endcase
        end
        CR10: begin
          case (bus.in)
            COIN_NONE: begin
              state      <= IDLE;
              bus.change <= CHG_10;
            end
            COIN_5: begin
              state   <= IDLE;
              bus.out <= 1'b1;
            end
            COIN_10: begin
              state      <= IDLE;
              bus.out    <= 1'b1;
              bus.change <= CHG_5;
            end
            default: state <= CR10;
          endcase
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef VM_SALE_CNT_EN
  logic sale;

  assign sale = ((state == CR5)  && (bus.in == COIN_10)) ||
                ((state == CR10) && ((bus.in == COIN_5) || (bus.in == COIN_10)));

  // Counts exactly the edges that register a dispense pulse; wraps naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sale_count <= 8'd0;
    end else if (sale) begin
      sale_count <= sale_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vending_machine.sv
// Self-checking bench for vending_machine against a credit-arithmetic model.
// Define VM_SALE_CNT_EN to also check the sale counter and its wrap.
module tb_vending_machine;

  logic clk;
  logic reset;
  vending_machine_if bus();

`ifdef VM_SALE_CNT_EN
  logic [7:0] sale_count;
`endif

  vending_machine dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus)
`ifdef VM_SALE_CNT_EN
    ,
    .sale_count (sale_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run;
  int tests_failed;
  int credit;
  int exp_out;
  int exp_change;
  int exp_count;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    tests_run++;
    if (actual != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic modelReset();
    credit     = 0;
    exp_out    = 0;
    exp_change = 0;
    exp_count  = 0;
  endtask

  // Model: credit is a plain sum; a gap refunds it, reaching the price sells.
  task automatic modelStep(input logic [1:0] coin);
    exp_out    = 0;
    exp_change = 0;
    if (coin == 2'b00) begin
      exp_change = credit / 5;
      credit     = 0;
    end else if (coin != 2'b11) begin
      credit = credit + ((coin == 2'b01) ? 5 : 10);
      if (credit >= 15) begin
        exp_out    = 1;
        exp_change = (credit - 15) / 5;
        credit     = 0;
        exp_count  = (exp_count + 1) % 256;
      end
    end
  endtask

  task automatic applyStimulus(input logic [1:0] coin, input string tag);
    bus.in = coin;
    @(posedge clk);
    modelStep(coin);
    #1;
    checkOutput({tag, "_out"}, int'(bus.out), exp_out);
    checkOutput({tag, "_chg"}, int'(bus.change), exp_change);
`ifdef VM_SALE_CNT_EN
    checkOutput({tag, "_cnt"}, int'(sale_count), exp_count);
`endif
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    modelReset();
    reset  = 1'b0;
    bus.in = 2'b01;

    repeat (2) begin
      @(negedge clk);
      checkOutput("rst_out", int'(bus.out), 0);
      checkOutput("rst_chg", int'(bus.change), 0);
    end
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(2'b01, "rel_5");
    applyStimulus(2'b00, "rel_refund");

    for (int i = 0; i < 3; i++) applyStimulus(2'b01, "three5");
    applyStimulus(2'b10, "over_a");
    applyStimulus(2'b10, "over_b");
    applyStimulus(2'b00, "over_idle");
    applyStimulus(2'b01, "exact_a");
    applyStimulus(2'b10, "exact_b");
    applyStimulus(2'b10, "exact_c");
    applyStimulus(2'b01, "exact_d");
    applyStimulus(2'b10, "ref10_a");
    applyStimulus(2'b00, "ref10_b");
    applyStimulus(2'b01, "ref5_a");
    applyStimulus(2'b00, "ref5_b");
    applyStimulus(2'b01, "bad_a");
    applyStimulus(2'b11, "bad_b");
    applyStimulus(2'b01, "bad_c");
    applyStimulus(2'b00, "bad_d");

    applyStimulus(2'b01, "midrst_a");
    applyStimulus(2'b10, "midrst_sale");
    #2 reset = 1'b0;
    modelReset();
    #1;
    checkOutput("midrst_async_out", int'(bus.out), 0);
    checkOutput("midrst_async_chg", int'(bus.change), 0);
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(2'b10, "midrst_c");
    #2 reset = 1'b0;
    credit = 0;
    exp_count = 0;
    #1;
    checkOutput("midrst2_out", int'(bus.out), 0);
    checkOutput("midrst2_chg", int'(bus.change), 0);
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(2'b00, "midrst_norefund");

    for (int i = 0; i < 400; i++) begin
      applyStimulus(2'($urandom_range(0, 3)), "rand");
    end

`ifdef VM_SALE_CNT_EN
    applyStimulus(2'b00, "wrap_flush");
    @(negedge clk);
    reset = 1'b0;
    modelReset();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 257; i++) begin
      applyStimulus(2'b01, "wrap_a");
      applyStimulus(2'b10, "wrap_b");
    end
    checkOutput("wrap_final", int'(sale_count), 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
